// File: rtl/axi_pkg.sv
// Purpose: shared AXI4 encodings and the write-initiator FSM state type.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: burst_e (FIXED/INCR/WRAP), resp_e (OKAY..DECERR), wr_state_e.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi_burst_wr_mst.sv
// Purpose: AXI4 write-burst initiator; one command -> AW, len+1 W beats with wlast, B collect.
// Latency: cmd accept -> awvalid 1 cycle; 1-beat zero-wait burst completes in 4 cycles.
// Backpressure: cmd held off outside IDLE; W is a pass-through so src and slave stall each other.
// Ports: clk_i/rst_i; cmd_* command port; src_* streaming data in; done_o/err_o status;
//        m_axi_aw*/w*/b* AXI4 write channels (prot/cache 0, wstrb all ones).
module axi_burst_wr_mst
  import axi_pkg::*;
#(
  parameter int AXI_DW_g = 64,
  parameter int AXI_AW_g = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [AXI_AW_g-1:0]   cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [1:0]            cmd_burst_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [AXI_DW_g-1:0]   src_data_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,
  output logic [AXI_AW_g-1:0]   m_axi_awaddr_o,
  output logic [7:0]            m_axi_awlen_o,
  output logic [2:0]            m_axi_awsize_o,
  output logic [1:0]            m_axi_awburst_o,
  output logic [2:0]            m_axi_awprot_o,
  output logic [3:0]            m_axi_awcache_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,
  output logic [AXI_DW_g-1:0]   m_axi_wdata_o,
  output logic [AXI_DW_g/8-1:0] m_axi_wstrb_o,
  output logic                  m_axi_wlast_o,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o,
  input  logic [1:0]            m_axi_bresp_i
);

  wr_state_e           r_state;
  logic [AXI_AW_g-1:0] r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [7:0]          r_cnt;
  logic                r_err;

  logic w_in_data;
  logic w_wvalid;
  logic w_w_hs;
  logic w_is_last;

  assign w_in_data = (r_state == ST_DATA);
  assign w_wvalid  = w_in_data & src_valid_i;
  assign w_w_hs    = w_wvalid & m_axi_wready_i;
  assign w_is_last = (r_cnt == r_len);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_addr  <= cmd_addr_i;
            r_len   <= cmd_len_i;
            r_size  <= cmd_size_i;
            r_burst <= cmd_burst_i;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_awready_i) r_state <= ST_DATA;
        end
        ST_DATA: begin
          // The counter stops at len rather than incrementing past it, so
          // len=255 never wraps back to 0.
          if (w_w_hs) begin
            if (w_is_last) r_state <= ST_RESP;
            else           r_cnt   <= r_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid_i) begin
            r_err   <= (resp_e'(m_axi_bresp_i) != RESP_OKAY);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o     = (r_state == ST_IDLE);

  assign m_axi_awvalid_o = (r_state == ST_ADDR);
  assign m_axi_awaddr_o  = r_addr;
  assign m_axi_awlen_o   = r_len;
  assign m_axi_awsize_o  = r_size;
  assign m_axi_awburst_o = r_burst;
  assign m_axi_awprot_o  = 3'd0;
  assign m_axi_awcache_o = 4'd0;

  // W channel is a straight wire between source and slave while in DATA;
  // data is forced to zero elsewhere so nothing leaks out after reset.
  assign m_axi_wvalid_o  = w_wvalid;
  assign src_ready_o     = w_in_data & m_axi_wready_i;
  assign m_axi_wdata_o   = w_in_data ? src_data_i : '0;
  assign m_axi_wstrb_o   = '1;
  assign m_axi_wlast_o   = w_is_last & w_wvalid;

  assign m_axi_bready_o  = (r_state == ST_RESP);
  assign done_o          = (r_state == ST_RESP) & m_axi_bvalid_i;
  assign err_o           = r_err;

endmodule
